// File: rtl/fft_pkg.sv
// fft_pkg: shared sizing, FSM state type and address helpers for the radix-2 DIT
// FFT address generator (fft_addr_gen) and its delay line (fft_delay_line).
//
// Contents:
//   N_LOG2, N, ADDR_W, DATA_W, BFLY_LAT, D  - FFT geometry and pipeline depth
//   fftState_t                              - sequencer states
//   stageHalf / bflyAddr1 / twIndex         - butterfly address arithmetic
package fft_pkg;

    localparam int unsigned N_LOG2   = 5;
    localparam int unsigned N        = 1 << N_LOG2;
    localparam int unsigned ADDR_W   = N_LOG2;
    localparam int unsigned DATA_W   = 64;
    localparam int unsigned BFLY_LAT = 3;
    // Memory read latency (1) plus butterfly latency.
    localparam int unsigned D        = 1 + BFLY_LAT;

    localparam int unsigned B_W      = N_LOG2 - 1;   // butterfly counter width
    localparam int unsigned TW_W     = N_LOG2 - 1;   // twiddle index width
    localparam int unsigned STAGE_W  = 3;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        DRAIN,
        FLIP,
        DONE
    } fftState_t;

    // Distance between the two legs of a butterfly in stage s.
    function automatic logic [ADDR_W-1:0] stageHalf(input logic [STAGE_W-1:0] s);
        return ADDR_W'(1) << s;
    endfunction

    // Upper-leg address: insert a zero bit at position s of the butterfly index.
    function automatic logic [ADDR_W-1:0] bflyAddr1(input logic [B_W-1:0]     b,
                                                    input logic [STAGE_W-1:0] s);
        logic [ADDR_W-1:0] bx;
        logic [ADDR_W-1:0] pos;
        bx  = {1'b0, b};
        pos = bx & (stageHalf(s) - ADDR_W'(1));
        return ((bx >> s) << (s + 1)) | pos;
    endfunction

    // Twiddle index: position within the group, scaled to the N/2-entry ROM.
    function automatic logic [TW_W-1:0] twIndex(input logic [B_W-1:0]     b,
                                                input logic [STAGE_W-1:0] s);
        logic [ADDR_W-1:0] bx;
        logic [ADDR_W-1:0] pos;
        bx  = {1'b0, b};
        pos = bx & (stageHalf(s) - ADDR_W'(1));
        return TW_W'(pos << (B_W - s));
    endfunction

endpackage

// File: rtl/fft_delay_line.sv
// fft_delay_line: fixed-depth shift register carrying {valid, addr_1, addr_2} from the
// read cycle to the write cycle.
//
// Ports:
//   clk      system clock
//   rst      asynchronous active-high reset, clears every stage
//   din      entry entering the line this cycle
//   dout     entry leaving the line (Depth cycles after entry)
//   pending  a valid entry will still be inside the line after the next edge
module fft_delay_line #(
    parameter int unsigned Depth = 4,
    parameter int unsigned Width = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [Width-1:0] din,
    output logic [Width-1:0] dout,
    output logic             pending
);

    logic [Width-1:0] pipe [Depth];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(Depth); i++) begin
                pipe[i] <= '0;
            end
        end else begin
            pipe[0] <= din;
            for (int i = 1; i < int'(Depth); i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign dout = pipe[Depth-1];

    // The last stage is being written out this cycle, so it does not count.
    always_comb begin
        pending = 1'b0;
        for (int i = 0; i + 1 < int'(Depth); i++) begin
            pending = pending | pipe[i][Width-1];
        end
    end

endmodule

// File: rtl/fft_addr_gen.sv
// fft_addr_gen: sequencer and address generator for an in-place radix-2 DIT FFT over a
// two-bank ping-pong memory. Walks N_LOG2 stages of N/2 butterflies, emits read
// addresses, twiddle index and butterfly valid, and delayed write addresses.
//
// Optional feature: define FFT_AGU_STALL_EN to add the stall input, which freezes the
// butterfly counter during READ without stopping the write pipeline.
//
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   start          begin a run (sampled in IDLE only)
//   stall          (FFT_AGU_STALL_EN only) hold the current butterfly in READ
//   busy, done     run in progress / one-cycle completion pulse
//   stage          current stage index
//   select         bank select, 0 = read bank A / write bank B
//   write_enable   memory write strobe, with addw_1/addw_2
//   addr_1/addr_2  read addresses (0 outside READ)
//   tw_idx         twiddle ROM index, aligned with memory dout and bfly_valid
module fft_addr_gen
    import fft_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
`ifdef FFT_AGU_STALL_EN
    input  logic                stall,
`endif
    output logic                busy,
    output logic                done,
    output logic [STAGE_W-1:0]  stage,
    output logic                select,
    output logic                write_enable,
    output logic [ADDR_W-1:0]   addr_1,
    output logic [ADDR_W-1:0]   addr_2,
    output logic [ADDR_W-1:0]   addw_1,
    output logic [ADDR_W-1:0]   addw_2,
    output logic [TW_W-1:0]     tw_idx,
    output logic                bfly_valid
);

    localparam int unsigned PIPE_W = 1 + 2 * ADDR_W;

    fftState_t          state;
    logic [STAGE_W-1:0] stageQ;
    logic [B_W-1:0]     bQ;
    logic               selQ;
    logic               busyQ;
    logic               doneQ;
    logic               bvQ;
    logic [TW_W-1:0]    twQ;

    logic               stallIn;
    logic               inRead;
    logic               issue;
    logic [ADDR_W-1:0]  rdAddr1;
    logic [ADDR_W-1:0]  rdAddr2;
    logic [TW_W-1:0]    rdTw;
    logic [PIPE_W-1:0]  pipeIn;
    logic [PIPE_W-1:0]  pipeOut;
    logic               pending;

`ifdef FFT_AGU_STALL_EN
    assign stallIn = stall;
`else
    assign stallIn = 1'b0;
`endif

    always_comb begin
        inRead  = (state == READ);
        issue   = inRead & ~stallIn;
        rdAddr1 = '0;
        rdAddr2 = '0;
        rdTw    = '0;
        if (inRead) begin
            rdAddr1 = bflyAddr1(bQ, stageQ);
            rdAddr2 = rdAddr1 + stageHalf(stageQ);
            rdTw    = twIndex(bQ, stageQ);
        end
        // Stalled cycles enter the line as empty bubbles.
        pipeIn = issue ? {1'b1, rdAddr1, rdAddr2} : '0;
    end

    fft_delay_line #(
        .Depth (D),
        .Width (PIPE_W)
    ) u_delay (
        .clk     (clk),
        .rst     (rst),
        .din     (pipeIn),
        .dout    (pipeOut),
        .pending (pending)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            stageQ <= '0;
            bQ     <= '0;
            selQ   <= 1'b0;
            busyQ  <= 1'b0;
            doneQ  <= 1'b0;
            bvQ    <= 1'b0;
            twQ    <= '0;
        end else begin
            doneQ <= 1'b0;
            // Memory read takes one cycle, so valid/twiddle follow the address by one.
            bvQ   <= issue;
            twQ   <= issue ? rdTw : '0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state  <= READ;
                        stageQ <= '0;
                        bQ     <= '0;
                        busyQ  <= 1'b1;
                    end
                end
                READ: begin
                    if (!stallIn) begin
                        if (bQ == B_W'(N / 2 - 1)) begin
                            state <= DRAIN;
                        end else begin
                            bQ <= bQ + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (!pending) begin
                        state <= FLIP;
                    end
                end
                FLIP: begin
                    selQ <= ~selQ;
                    if (stageQ == STAGE_W'(N_LOG2 - 1)) begin
                        state <= DONE;
                        doneQ <= 1'b1;
                    end else begin
                        stageQ <= stageQ + 1'b1;
                        bQ     <= '0;
                        state  <= READ;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busyQ <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy         = busyQ;
    assign done         = doneQ;
    assign stage        = stageQ;
    assign select       = selQ;
    assign addr_1       = rdAddr1;
    assign addr_2       = rdAddr2;
    assign tw_idx       = twQ;
    assign bfly_valid   = bvQ;
    assign write_enable = pipeOut[PIPE_W-1];
    assign addw_1       = pipeOut[2*ADDR_W-1:ADDR_W];
    assign addw_2       = pipeOut[ADDR_W-1:0];

endmodule

// File: doc/fft_addr_gen.md
Name: fft_addr_gen

Overview:
- Sequencer and address generator for the in-place radix-2 DIT FFT. Sits directly upstream of the two-bank ping-pong memory and drives its select, write_enable, read and write address ports.
- Walks all log2(N) stages of butterflies and supplies the twiddle index and valid strobe to the butterfly datapath.
- Delays write addresses to match the memory read latency plus butterfly latency.
- Flips bank select between stages.

Parameters:
- N_LOG2, 5, log2 of FFT length; N = 32 points, 16 butterflies per stage.
- BFLY_LAT, 3, butterfly datapath latency in cycles from dout valid to result valid.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  begin an FFT run; sampled only in IDLE.
- busy  out  1  high while a run is in progress.
- done  out  1  one-cycle pulse when a run completes.
- stage  out  3  current stage index, 0..N_LOG2-1.
- select  out  1  bank select to memory; 0 = read bank A / write bank B.
- write_enable  out  1  memory write strobe.
- addr_1  out  N_LOG2  read address, upper butterfly leg.
- addr_2  out  N_LOG2  read address, lower butterfly leg.
- addw_1  out  N_LOG2  write address, upper leg.
- addw_2  out  N_LOG2  write address, lower leg.
- tw_idx  out  N_LOG2-1  twiddle ROM index, aligned with memory dout.
- bfly_valid  out  1  memory dout pair is valid this cycle, aligned with tw_idx.

Behaviour:
- Reset values:
  - FSM = IDLE; stage, butterfly counter b, select = 0.
  - busy, done, write_enable, bfly_valid = 0.
  - All address outputs and tw_idx = 0.
  - Delay pipeline cleared.
- Pipeline depth: D = 1 + BFLY_LAT (default 4).
- Every output is a function of registers only; there is no combinational path from start.
- FSM states:
  - IDLE: start=1 -> READ with b=0, stage=0, busy=1.
  - READ: issue one butterfly per cycle. When b=N/2-1, go to DRAIN; otherwise b increments.
  - DRAIN: wait until the delay pipeline holds no valid entry, then go to FLIP.
  - FLIP (1 cycle): select toggles. If stage=N_LOG2-1 go to DONE; else stage++, b=0, go to READ.
  - DONE (1 cycle): done=1, then go to IDLE; busy drops on IDLE entry.
- Address generation (stage s, half = 1<<s, pos = b & (half-1)):
  - addr_1 = ((b>>s)<<(s+1)) | pos.
  - addr_2 = addr_1 + half.
  - Twiddle index = pos << (N_LOG2-1-s).
  - Address outputs are 0 outside READ.
- Alignment:
  - tw_idx and bfly_valid are the read-cycle values delayed 1 cycle.
  - addw_1, addw_2 and write_enable are the read-cycle addr_1, addr_2 and valid delayed D cycles.
  - Writes go in place, to the other bank.
- Timing, with start sampled in IDLE at cycle T:
  - READ covers T+1..T+16.
  - Stage i FLIP at T+(i+1)(17+D).
  - done at T+5(17+D)+1, i.e. T+106 for the default parameters.
- select is constant from the first read of a stage through its last write.
- After done, select=1: bank B holds the result and is the read bank.
- Boundary conditions:
  - start while busy: ignored.
  - start held high through DONE: a new run begins from the IDLE cycle that follows.
  - rst mid-run: all state returns to reset values immediately and in-flight writes are discarded.
  - The b counter never wraps inside a stage.

Optional Feature:
- Macro: FFT_AGU_STALL_EN.
- Defined:
  - Adds input port stall (1 bit).
  - While stall=1 in READ: b holds, and no valid is issued into the delay pipeline that cycle.
  - The pipeline keeps shifting, so earlier writes still complete.
  - stall has no effect outside READ.
  - Stage and done timing stretch by exactly the number of stalled READ cycles.
- Undefined: no stall port; READ is always N/2 consecutive cycles.

Decomposition:
- Shared package fft_pkg:
  - N_LOG2, N, ADDR_W, DATA_W=64, BFLY_LAT, derived D.
  - FSM state enum {IDLE, READ, DRAIN, FLIP, DONE}.
- One sub-module fft_delay_line: parameterised depth and width shift register carrying {valid, addr_1, addr_2}. Reset clears the valid bits.

Test Plan:
- Reset then idle 10 cycles -> all outputs 0, select=0, no write_enable.
- start at T -> stage 0 addr_1/addr_2 = 0/1, 2/3, … 30/31; write_enable first at T+1+D with addw_1/addw_2=0/1; done at T+106; select=1 after.
- Stage 4 -> addr pairs b/b+16, tw_idx = b, appearing 1 cycle after each address; stage 2, b=5 -> addr 9/13, tw_idx 4.
- start pulsed during busy at T+50 -> ignored; done still at T+106; only one run.
- rst asserted at T+30 (stage 1, mid-READ) -> next cycle busy=0, write_enable=0, select=0; a fresh start completes normally.
- FFT_AGU_STALL_EN, stall high 3 cycles in stage 0 READ -> no duplicate or missing write addresses; done at T+109.
